// File: rtl/croc_soc_periph.sv
// Croc SoC peripheral hub: SoC-control registers, GPIO bank and byte-wide SPI master.
// Optional feature: define CROC_TSPI_EN to build the TSPI registers and FSM;
// without it the TSPI offsets decode as unmapped and the SPI pins are held idle.
module croc_soc_periph #(
    parameter int unsigned GpioCount       = 32,
    parameter logic [31:0] BootAddrDefault = 32'h1000_0000,
    parameter logic [7:0]  TspiDivDefault  = 8'd4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [7:0]           addr_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    input  logic                 fetch_en_i,
    output logic                 fetch_en_o,
    output logic [31:0]          boot_addr_o,
    output logic                 status_o,
    input  logic [GpioCount-1:0] gpio_i,
    output logic [GpioCount-1:0] gpio_o,
    output logic [GpioCount-1:0] gpio_out_en_o,
    output logic                 tspi_clk_o,
    output logic                 tspi_mosi_o,
    input  logic                 tspi_miso_i,
    output logic                 tspi_cs_no
);

    localparam logic [5:0] REG_BOOTADDR   = 6'h00;
    localparam logic [5:0] REG_FETCHEN    = 6'h01;
    localparam logic [5:0] REG_CORESTATUS = 6'h02;
    localparam logic [5:0] REG_GPIO_DIR   = 6'h04;
    localparam logic [5:0] REG_GPIO_OUT   = 6'h05;
    localparam logic [5:0] REG_GPIO_IN    = 6'h06;
`ifdef CROC_TSPI_EN
    localparam logic [5:0] REG_TSPI_CTRL  = 6'h08;
    localparam logic [5:0] REG_TSPI_DATA  = 6'h09;
    localparam logic [5:0] REG_TSPI_STAT  = 6'h0A;
`endif

    logic [5:0]           reg_idx;
    logic                 wr;
    logic [31:0]          be_mask;
    logic [31:0]          rd_data;
    logic                 mapped;
    logic                 wr_err;
    logic [31:0]          boot_addr;
    logic                 fetch_en;
    logic [31:0]          core_status;
    logic [GpioCount-1:0] gpio_dir;
    logic [GpioCount-1:0] gpio_out;
    logic [GpioCount-1:0] gpio_sync1;
    logic [GpioCount-1:0] gpio_sync2;
    logic [31:0]          dir_next;
    logic [31:0]          out_next;
    logic                 busy;
    logic                 unused_addr;

    assign reg_idx     = addr_i[7:2];
    assign wr          = req_i & we_i;
    assign unused_addr = ^addr_i[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Expand byte enables into a bit mask
    always_comb begin
        be_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            be_mask[8*i +: 8] = {8{be_i[i]}};
        end
    end

    assign dir_next = merge(32'(gpio_dir), wdata_i, be_mask);
    assign out_next = merge(32'(gpio_out), wdata_i, be_mask);

`ifdef CROC_TSPI_EN
    typedef enum logic {IDLE, XFER} tspi_state_t;

    tspi_state_t state, state_next;
    logic [7:0]  div;
    logic        cs_force;
    logic [7:0]  tick;
    logic [3:0]  toggle_cnt;
    logic        sck;
    logic        mosi;
    logic [7:0]  tx;
    logic [6:0]  rx_shift;
    logic [7:0]  rx;
    logic        tick_done;
    logic        last;
    logic        start;
    logic        sel_ctrl;
    logic        sel_data;

    assign sel_ctrl  = wr & (reg_idx == REG_TSPI_CTRL);
    assign sel_data  = wr & (reg_idx == REG_TSPI_DATA);
    // >= keeps the half-period bounded if div is lowered mid-transfer
    assign tick_done = (tick >= div);
    assign last      = (state == XFER) & tick_done & (toggle_cnt == 4'd15);
    assign start     = sel_data & ~busy & be_i[0];
    assign wr_err    = sel_data & busy;

    // TSPI state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // TSPI next-state and busy flag
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: if (start) state_next = XFER;
            XFER: begin
                busy = 1'b1;
                if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // TSPI control register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div      <= TspiDivDefault;
            cs_force <= 1'b0;
        end else if (sel_ctrl) begin
            if (be_i[0]) cs_force <= wdata_i[0];
            if (be_i[1]) div      <= wdata_i[15:8];
        end
    end

    // SCK generation, MOSI shift on falling edges, MISO sample on rising edges
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick       <= '0;
            toggle_cnt <= '0;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            tx         <= '0;
            rx_shift   <= '0;
            rx         <= '0;
        end else if (start) begin
            tick       <= '0;
            toggle_cnt <= '0;
            sck        <= 1'b0;
            tx         <= wdata_i[7:0];
            mosi       <= wdata_i[7];
        end else if (state == XFER) begin
            if (tick_done) begin
                tick       <= '0;
                toggle_cnt <= toggle_cnt + 4'd1;
                sck        <= ~sck;
                if (!sck) begin
                    rx_shift <= {rx_shift[5:0], tspi_miso_i};
                    if (toggle_cnt == 4'd14) rx <= {rx_shift, tspi_miso_i};
                end else begin
                    tx   <= {tx[6:0], 1'b0};
                    mosi <= last ? 1'b0 : tx[6];
                end
            end else begin
                tick <= tick + 8'd1;
            end
        end
    end

    assign tspi_clk_o  = sck;
    assign tspi_mosi_o = mosi;
    assign tspi_cs_no  = ~(busy | cs_force);
`else
    logic unused_miso;

    assign busy        = 1'b0;
    assign wr_err      = 1'b0;
    assign tspi_clk_o  = 1'b0;
    assign tspi_mosi_o = 1'b0;
    assign tspi_cs_no  = 1'b1;
    assign unused_miso = tspi_miso_i;
`endif

    // Address decode and read mux
    always_comb begin
        mapped  = 1'b1;
        rd_data = '0;
        case (reg_idx)
            REG_BOOTADDR:   rd_data = boot_addr;
            REG_FETCHEN:    rd_data = {31'b0, fetch_en};
            REG_CORESTATUS: rd_data = core_status;
            REG_GPIO_DIR:   rd_data = 32'(gpio_dir);
            REG_GPIO_OUT:   rd_data = 32'(gpio_out);
            REG_GPIO_IN:    rd_data = 32'(gpio_sync2);
`ifdef CROC_TSPI_EN
            REG_TSPI_CTRL:  rd_data = {16'b0, div, 7'b0, cs_force};
            REG_TSPI_DATA:  rd_data = {24'b0, rx};
            REG_TSPI_STAT:  rd_data = {31'b0, busy};
`endif
            default:        mapped = 1'b0;
        endcase
    end

    // SoC-control and GPIO registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            boot_addr   <= BootAddrDefault;
            fetch_en    <= 1'b0;
            core_status <= '0;
            gpio_dir    <= '0;
            gpio_out    <= '0;
        end else if (wr) begin
            case (reg_idx)
                REG_BOOTADDR:   boot_addr   <= merge(boot_addr, wdata_i, be_mask);
                REG_FETCHEN:    if (be_i[0]) fetch_en <= wdata_i[0];
                REG_CORESTATUS: core_status <= merge(core_status, wdata_i, be_mask);
                REG_GPIO_DIR:   gpio_dir    <= dir_next[GpioCount-1:0];
                REG_GPIO_OUT:   gpio_out    <= out_next[GpioCount-1:0];
                default: ;
            endcase
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= gpio_i;
            gpio_sync2 <= gpio_sync1;
        end
    end

    // Bus response one cycle after grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= (req_i && !we_i) ? rd_data : '0;
            err_o    <= req_i & (~mapped | wr_err);
        end
    end

    assign gnt_o         = req_i;
    assign fetch_en_o    = fetch_en_i | fetch_en;
    assign boot_addr_o   = boot_addr;
    assign status_o      = |core_status;
    assign gpio_o        = gpio_out;
    assign gpio_out_en_o = gpio_dir;

endmodule

// File: tb/tb_croc_soc_periph.sv
module tb_croc_soc_periph;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic        fetch_en_in, fetch_en_out;
    logic [31:0] boot_addr;
    logic        status;
    logic [31:0] gpio_in, gpio_out, gpio_oe, gpio_drive;
    logic        sck, mosi, miso, cs_n;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] m_boot, m_status, m_dir, m_out;
    logic        m_fetch, m_csf;
    logic [7:0]  m_div, m_rx;

    int          sck_rises;
    logic [7:0]  mosi_bits;
    logic [7:0]  rw_addrs [5] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14};

    assign gpio_in = {gpio_drive[31:8], gpio_out[3:0] & gpio_oe[3:0], gpio_drive[3:0]};
    assign miso    = mosi;

    always #5 clk = ~clk;

    always @(posedge sck) begin
        sck_rises = sck_rises + 1;
        mosi_bits = {mosi_bits[6:0], mosi};
    end

    croc_soc_periph dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .fetch_en_i(fetch_en_in), .fetch_en_o(fetch_en_out), .boot_addr_o(boot_addr),
        .status_o(status), .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_out_en_o(gpio_oe),
        .tspi_clk_o(sck), .tspi_mosi_o(mosi), .tspi_miso_i(miso), .tspi_cs_no(cs_n)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic bit is_mapped(input logic [7:0] a);
        case (a & 8'hFC)
            8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18: return 1'b1;
`ifdef CROC_TSPI_EN
            8'h20, 8'h24, 8'h28: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a & 8'hFC)
            8'h00: return m_boot;
            8'h04: return {31'b0, m_fetch};
            8'h08: return m_status;
            8'h10: return m_dir;
            8'h14: return m_out;
            8'h18: return {gpio_drive[31:8], m_out[3:0] & m_dir[3:0], gpio_drive[3:0]};
`ifdef CROC_TSPI_EN
            8'h20: return {16'b0, m_div, 7'b0, m_csf};
            8'h24: return {24'b0, m_rx};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
        case (a & 8'hFC)
            8'h00: m_boot = merge(m_boot, d, b);
            8'h04: if (b[0]) m_fetch = d[0];
            8'h08: m_status = merge(m_status, d, b);
            8'h10: m_dir = merge(m_dir, d, b);
            8'h14: m_out = merge(m_out, d, b);
`ifdef CROC_TSPI_EN
            8'h20: begin
                if (b[0]) m_csf = d[0];
                if (b[1]) m_div = d[15:8];
            end
`endif
            default: ;
        endcase
    endtask

    task automatic model_reset;
        m_boot = 32'h1000_0000; m_status = 0; m_dir = 0; m_out = 0;
        m_fetch = 0; m_csf = 0; m_div = 8'd4; m_rx = 0;
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [3:0] b, input logic [31:0] d,
                       output logic g, output logic rv, output logic [31:0] rd, output logic er);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        #1 g = gnt;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        rv = rvalid; rd = rdata; er = err;
    endtask

    task automatic test_reset;
        logic g, rv, er; logic [31:0] rd;
        rst = 1'b1; fetch_en_in = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        checks++; if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin failures++;
            $display("FAIL reset_bus got rvalid=%b err=%b rdata=%h exp 0/0/0", rvalid, err, rdata); end
        checks++; if (boot_addr !== 32'h1000_0000 || status !== 1'b0) begin failures++;
            $display("FAIL reset_ctrl got boot=%h status=%b exp 10000000/0", boot_addr, status); end
        checks++; if (gpio_out !== 32'h0 || gpio_oe !== 32'h0) begin failures++;
            $display("FAIL reset_gpio got out=%h oe=%h exp 0/0", gpio_out, gpio_oe); end
        checks++; if (sck !== 1'b0 || mosi !== 1'b0 || cs_n !== 1'b1) begin failures++;
            $display("FAIL reset_tspi got sck=%b mosi=%b cs_n=%b exp 0/0/1", sck, mosi, cs_n); end
        checks++; if (fetch_en_out !== 1'b0) begin failures++;
            $display("FAIL reset_fetch0 got %b exp 0", fetch_en_out); end
        fetch_en_in = 1'b1; #1;
        checks++; if (fetch_en_out !== 1'b1) begin failures++;
            $display("FAIL reset_fetch1 got %b exp 1", fetch_en_out); end
        fetch_en_in = 1'b0;
        @(negedge clk); rst = 1'b0;
        bus(1'b0, 8'h00, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (g !== 1'b1 || rv !== 1'b1 || er !== 1'b0 || rd !== 32'h1000_0000) begin failures++;
            $display("FAIL reset_read_boot got g=%b rv=%b err=%b rd=%h exp 1/1/0/10000000", g, rv, er, rd); end
        bus(1'b0, 8'h08, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++;
            $display("FAIL reset_read_status got rd=%h err=%b exp 0/0", rd, er); end
    endtask

    task automatic test_ctrl_regs;
        logic g, rv, er; logic [31:0] rd, d; logic [7:0] a; logic [3:0] b;
        bus(1'b1, 8'h00, 4'hF, 32'h1234_5678, g, rv, rd, er); model_write(8'h00, 4'hF, 32'h1234_5678);
        bus(1'b0, 8'h00, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'h1234_5678) begin failures++;
            $display("FAIL boot_full got %h exp 12345678", rd); end
        bus(1'b1, 8'h00, 4'h1, 32'h0, g, rv, rd, er); model_write(8'h00, 4'h1, 32'h0);
        bus(1'b0, 8'h00, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'h1234_5600) begin failures++;
            $display("FAIL boot_be1 got %h exp 12345600", rd); end
        bus(1'b1, 8'h08, 4'hF, 32'h1, g, rv, rd, er); model_write(8'h08, 4'hF, 32'h1);
        checks++; if (status !== 1'b1) begin failures++;
            $display("FAIL status_set got %b exp 1", status); end
        bus(1'b1, 8'h04, 4'hF, 32'h1, g, rv, rd, er); model_write(8'h04, 4'hF, 32'h1);
        checks++; if (fetch_en_out !== 1'b1) begin failures++;
            $display("FAIL fetch_reg got %b exp 1", fetch_en_out); end
        for (int i = 0; i < 24; i++) begin
            a = rw_addrs[$urandom_range(0, 4)] | 8'($urandom_range(0, 3));
            b = 4'($urandom_range(0, 15));
            d = $urandom;
            fetch_en_in = 1'($urandom_range(0, 1));
            bus(1'b1, a, b, d, g, rv, rd, er); model_write(a, b, d);
            checks++; if (g !== 1'b1 || rv !== 1'b1 || er !== 1'b0) begin failures++;
                $display("FAIL rand_wr_resp a=%h got g=%b rv=%b err=%b exp 1/1/0", a, g, rv, er); end
            checks++; if (boot_addr !== m_boot || status !== (m_status != 0) || fetch_en_out !== (fetch_en_in | m_fetch)
                          || gpio_out !== m_out || gpio_oe !== m_dir) begin failures++;
                $display("FAIL rand_outputs got boot=%h st=%b fe=%b out=%h oe=%h exp %h/%b/%b/%h/%h", boot_addr, status,
                         fetch_en_out, gpio_out, gpio_oe, m_boot, m_status != 0, fetch_en_in | m_fetch, m_out, m_dir); end
            bus(1'b0, a, 4'h0, 32'h0, g, rv, rd, er);
            checks++; if (rd !== model_read(a) || er !== 1'b0) begin failures++;
                $display("FAIL rand_readback a=%h got %h err=%b exp %h/0", a, rd, er, model_read(a)); end
        end
        fetch_en_in = 1'b0;
    endtask

    task automatic test_gpio;
        logic g, rv, er; logic [31:0] rd, dir, out;
        for (int i = 0; i < 8; i++) begin
            dir = (i == 0) ? 32'hF : $urandom;
            out = (i == 0) ? 32'h5 : $urandom;
            gpio_drive = $urandom;
            bus(1'b1, 8'h10, 4'hF, dir, g, rv, rd, er); model_write(8'h10, 4'hF, dir);
            bus(1'b1, 8'h14, 4'hF, out, g, rv, rd, er); model_write(8'h14, 4'hF, out);
            repeat (3) @(negedge clk);
            bus(1'b0, 8'h18, 4'h0, 32'h0, g, rv, rd, er);
            checks++; if (rd !== model_read(8'h18)) begin failures++;
                $display("FAIL gpio_in got %h exp %h", rd, model_read(8'h18)); end
            if (i == 0) begin
                checks++; if (rd[7:4] !== 4'h5) begin failures++;
                    $display("FAIL gpio_loop got %h exp 5", rd[7:4]); end
            end
        end
        bus(1'b1, 8'h18, 4'hF, ~model_read(8'h18), g, rv, rd, er);
        checks++; if (er !== 1'b0 || rv !== 1'b1) begin failures++;
            $display("FAIL gpio_ro_write got err=%b rv=%b exp 0/1", er, rv); end
        bus(1'b0, 8'h18, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== model_read(8'h18)) begin failures++;
            $display("FAIL gpio_ro_keep got %h exp %h", rd, model_read(8'h18)); end
    endtask

    task automatic test_unmapped;
        logic g, rv, er, w; logic [31:0] rd; logic [7:0] a;
        for (int i = 0; i < 20; i++) begin
            if (i == 0) a = 8'h30;
            else do a = 8'($urandom_range(0, 255)); while (is_mapped(a));
            w = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            bus(w, a, 4'hF, $urandom, g, rv, rd, er);
            checks++; if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin failures++;
                $display("FAIL unmapped a=%h we=%b got rv=%b err=%b rd=%h exp 1/1/0", a, w, rv, er, rd); end
        end
        foreach (rw_addrs[k]) begin
            bus(1'b0, rw_addrs[k], 4'h0, 32'h0, g, rv, rd, er);
            checks++; if (rd !== model_read(rw_addrs[k])) begin failures++;
                $display("FAIL unmapped_nochange a=%h got %h exp %h", rw_addrs[k], rd, model_read(rw_addrs[k])); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] x;
        x = $urandom;
        @(negedge clk); req = 1'b1; we = 1'b1; addr = 8'h00; be = 4'hF; wdata = x;
        model_write(8'h00, 4'hF, x);
        @(negedge clk);
        checks++; if (rvalid !== 1'b1 || err !== 1'b0) begin failures++;
            $display("FAIL b2b_wr got rv=%b err=%b exp 1/0", rvalid, err); end
        we = 1'b0;
        @(negedge clk);
        checks++; if (rvalid !== 1'b1 || rdata !== x) begin failures++;
            $display("FAIL b2b_rd1 got rv=%b rd=%h exp 1/%h", rvalid, rdata, x); end
        addr = 8'h08;
        @(negedge clk);
        checks++; if (rvalid !== 1'b1 || rdata !== m_status) begin failures++;
            $display("FAIL b2b_rd2 got rv=%b rd=%h exp 1/%h", rvalid, rdata, m_status); end
        req = 1'b0;
        @(negedge clk);
        checks++; if (rvalid !== 1'b0) begin failures++;
            $display("FAIL b2b_idle got rv=%b exp 0", rvalid); end
    endtask

`ifdef CROC_TSPI_EN
    task automatic wait_cs_high(output bit done);
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (cs_n) done = 1'b1;
        end
    endtask

    task automatic test_tspi;
        logic g, rv, er; logic [31:0] rd; logic [7:0] data, div; int n; bit done;
        for (int t = 0; t < 6; t++) begin
            div  = (t == 0) ? 8'd0 : 8'($urandom_range(0, 3));
            data = (t == 0) ? 8'hA5 : 8'($urandom);
            bus(1'b1, 8'h20, 4'h3, {16'h0, div, 8'h00}, g, rv, rd, er); model_write(8'h20, 4'h3, {16'h0, div, 8'h00});
            sck_rises = 0; mosi_bits = 8'h0;
            bus(1'b1, 8'h24, 4'hF, {24'h0, data}, g, rv, rd, er);
            checks++; if (er !== 1'b0 || cs_n !== 1'b0) begin failures++;
                $display("FAIL tspi_start got err=%b cs_n=%b exp 0/0", er, cs_n); end
            n = 1; done = 1'b0;
            for (int k = 0; k < 2000 && !done; k++) begin
                @(negedge clk);
                if (cs_n) done = 1'b1; else n++;
            end
            checks++; if (!done || n != 16 * (int'(div) + 1)) begin failures++;
                $display("FAIL tspi_len div=%0d got %0d cycles done=%b exp %0d", div, n, done, 16 * (int'(div) + 1)); end
            checks++; if (sck_rises != 8 || mosi_bits !== data || sck !== 1'b0 || mosi !== 1'b0) begin failures++;
                $display("FAIL tspi_wave got rises=%0d bits=%h sck=%b mosi=%b exp 8/%h/0/0", sck_rises, mosi_bits, sck, mosi, data); end
            m_rx = data;
            bus(1'b0, 8'h24, 4'h0, 32'h0, g, rv, rd, er);
            checks++; if (rd !== model_read(8'h24)) begin failures++;
                $display("FAIL tspi_rx got %h exp %h", rd, model_read(8'h24)); end
            bus(1'b0, 8'h28, 4'h0, 32'h0, g, rv, rd, er);
            checks++; if (rd !== 32'h0) begin failures++;
                $display("FAIL tspi_idle_stat got %h exp 0", rd); end
        end
        bus(1'b1, 8'h20, 4'h2, 32'h0000_0300, g, rv, rd, er); model_write(8'h20, 4'h2, 32'h0000_0300);
        bus(1'b1, 8'h24, 4'hF, 32'h3C, g, rv, rd, er);
        bus(1'b0, 8'h28, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'h1 || er !== 1'b0) begin failures++;
            $display("FAIL tspi_busy got %h err=%b exp 1/0", rd, er); end
        bus(1'b1, 8'h24, 4'hF, 32'hFF, g, rv, rd, er);
        checks++; if (er !== 1'b1) begin failures++;
            $display("FAIL tspi_busy_write got err=%b exp 1", er); end
        wait_cs_high(done);
        m_rx = 8'h3C;
        bus(1'b0, 8'h24, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (!done || rd !== model_read(8'h24)) begin failures++;
            $display("FAIL tspi_busy_ignored got %h done=%b exp %h", rd, done, model_read(8'h24)); end
        bus(1'b1, 8'h20, 4'h1, 32'h1, g, rv, rd, er); model_write(8'h20, 4'h1, 32'h1);
        checks++; if (cs_n !== 1'b0) begin failures++;
            $display("FAIL tspi_cs_force got %b exp 0", cs_n); end
        bus(1'b0, 8'h20, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== model_read(8'h20)) begin failures++;
            $display("FAIL tspi_ctrl got %h exp %h", rd, model_read(8'h20)); end
        bus(1'b1, 8'h20, 4'h1, 32'h0, g, rv, rd, er); model_write(8'h20, 4'h1, 32'h0);
        checks++; if (cs_n !== 1'b1) begin failures++;
            $display("FAIL tspi_cs_release got %b exp 1", cs_n); end
    endtask

    task automatic test_reset_mid_xfer;
        logic g, rv, er; logic [31:0] rd;
        bus(1'b1, 8'h24, 4'hF, 32'hC3, g, rv, rd, er);
        repeat (5) @(negedge clk);
        checks++; if (cs_n !== 1'b0) begin failures++;
            $display("FAIL mid_active got cs_n=%b exp 0", cs_n); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (cs_n !== 1'b1 || sck !== 1'b0) begin failures++;
            $display("FAIL mid_reset got cs_n=%b sck=%b exp 1/0", cs_n, sck); end
        @(negedge clk); rst = 1'b0; model_reset();
        bus(1'b0, 8'h28, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'h0) begin failures++;
            $display("FAIL mid_stat got %h exp 0", rd); end
        bus(1'b0, 8'h20, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== model_read(8'h20)) begin failures++;
            $display("FAIL mid_ctrl got %h exp %h", rd, model_read(8'h20)); end
        bus(1'b0, 8'h24, 4'h0, 32'h0, g, rv, rd, er);
        checks++; if (rd !== 32'h0) begin failures++;
            $display("FAIL mid_rx got %h exp 0", rd); end
    endtask
`else
    task automatic test_tspi_absent;
        logic g, rv, er; logic [31:0] rd; logic [7:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 8'h20 + 8'(4 * i);
            bus(1'b0, a, 4'h0, 32'h0, g, rv, rd, er);
            checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++;
                $display("FAIL tspi_off_rd a=%h got err=%b rd=%h exp 1/0", a, er, rd); end
            bus(1'b1, a, 4'hF, $urandom, g, rv, rd, er);
            checks++; if (er !== 1'b1) begin failures++;
                $display("FAIL tspi_off_wr a=%h got err=%b exp 1", a, er); end
            repeat (4) @(negedge clk);
            checks++; if (sck !== 1'b0 || mosi !== 1'b0 || cs_n !== 1'b1) begin failures++;
                $display("FAIL tspi_off_pins got sck=%b mosi=%b cs_n=%b exp 0/0/1", sck, mosi, cs_n); end
        end
    endtask
`endif

    initial begin
        req = 1'b0; we = 1'b0; addr = 8'h0; be = 4'h0; wdata = 32'h0;
        gpio_drive = 32'h0; fetch_en_in = 1'b0; rst = 1'b1;
        sck_rises = 0; mosi_bits = 8'h0;
        model_reset();
        test_reset();
        test_ctrl_regs();
        test_gpio();
        test_unmapped();
        test_back_to_back();
`ifdef CROC_TSPI_EN
        test_tspi();
        test_reset_mid_xfer();
`else
        test_tspi_absent();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
